// File: rtl/cm_ahb_in_stage.sv
// Master-side AHB-Lite requester for one matrix slave port: raises req/pri toward the arbiter,
// parks the address phase while not granted, and relays the data-phase response.
// Optional locked-sequence support is built when CM_IN_STAGE_LOCK_EN is defined.
module cm_ahb_in_stage #(
  parameter int AW        = 32,
  parameter int PRI_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hsel_m,
  input  logic [AW-1:0]        haddr_m,
  input  logic [1:0]           htrans_m,
  input  logic                 hwrite_m,
  input  logic [2:0]           hsize_m,
  input  logic [2:0]           hburst_m,
  input  logic [3:0]           hprot_m,
  input  logic                 hmastlock_m,
  input  logic                 hready_m,
  output logic                 hreadyout_m,
  output logic                 hresp_m,
  input  logic [PRI_WIDTH-1:0] pri_cfg,
  output logic                 req,
  output logic [PRI_WIDTH-1:0] pri,
  input  logic                 gnt,
  output logic [AW-1:0]        haddr_s,
  output logic [1:0]           htrans_s,
  output logic                 hwrite_s,
  output logic [2:0]           hsize_s,
  output logic [2:0]           hburst_s,
  output logic [3:0]           hprot_s,
  output logic                 hmastlock_s,
  input  logic                 hready_s,
  input  logic                 hresp_s
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  state_t          state, state_nxt;
  logic            new_xfer, can_accept, accept, issue_direct, issue_held, capture;
  logic            req_base;
  logic [AW-1:0]   h_addr;
  logic            h_write;
  logic [2:0]      h_size;
  logic [2:0]      h_burst;
  logic [3:0]      h_prot;

  assign pri = pri_cfg;

  always_comb begin
    new_xfer     = hsel_m & htrans_m[1] & hready_m;
    // A new phase may only be taken when no data phase is outstanding or it is completing.
    can_accept   = rst_n & ((state == S_IDLE) | ((state == S_DATA) & hready_s));
    accept       = new_xfer & can_accept;
    issue_direct = accept & gnt;
    capture      = accept & ~gnt;
    issue_held   = rst_n & (state == S_WAIT) & gnt;
    req_base     = rst_n & ((state == S_WAIT) | (new_xfer & (state != S_WAIT)));
  end

  always_comb begin
    state_nxt = state;
    if (can_accept) begin
      if (accept) state_nxt = gnt ? S_DATA : S_WAIT;
      else        state_nxt = S_IDLE;
    end else if (issue_held) begin
      state_nxt = S_DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_addr  <= '0;
      h_write <= 1'b0;
      h_size  <= 3'b000;
      h_burst <= 3'b000;
      h_prot  <= 4'b0000;
    end else if (capture) begin
      h_addr  <= haddr_m;
      h_write <= hwrite_m;
      h_size  <= hsize_m;
      h_burst <= hburst_m;
      h_prot  <= hprot_m;
    end
  end

  always_comb begin
    haddr_s  = '0;
    htrans_s = 2'b00;
    hwrite_s = 1'b0;
    hsize_s  = 3'b000;
    hburst_s = 3'b000;
    hprot_s  = 4'b0000;
    if (state == S_WAIT) begin
      haddr_s  = h_addr;
      hwrite_s = h_write;
      hsize_s  = h_size;
      hburst_s = h_burst;
      hprot_s  = h_prot;
      // A parked SEQ lost its burst context at the slave, so it always restarts as NONSEQ.
      htrans_s = issue_held ? 2'b10 : 2'b00;
    end else if (issue_direct) begin
      haddr_s  = haddr_m;
      htrans_s = htrans_m;
      hwrite_s = hwrite_m;
      hsize_s  = hsize_m;
      hburst_s = hburst_m;
      hprot_s  = hprot_m;
    end
  end

  always_comb begin
    hreadyout_m = 1'b1;
    hresp_m     = 1'b0;
    case (state)
      S_WAIT: hreadyout_m = 1'b0;
      S_DATA: begin
        hreadyout_m = hready_s;
        hresp_m     = hresp_s;
      end
      default: ;
    endcase
  end

`ifdef CM_IN_STAGE_LOCK_EN
  logic h_lock, lock_q, dlock_q, issue_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       h_lock <= 1'b0;
    else if (capture) h_lock <= hmastlock_m;
  end

  assign issue_lock = issue_direct ? hmastlock_m : h_lock;

  // Lock is held until a transfer that was issued unlocked finishes its data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q  <= 1'b0;
      dlock_q <= 1'b0;
    end else begin
      if (issue_direct | issue_held) dlock_q <= issue_lock;
      if ((issue_direct | issue_held) & issue_lock)
        lock_q <= 1'b1;
      else if ((state == S_DATA) & hready_s & ~dlock_q)
        lock_q <= 1'b0;
    end
  end

  always_comb begin
    req         = req_base | (rst_n & lock_q);
    hmastlock_s = 1'b0;
    if (state == S_WAIT)   hmastlock_s = h_lock;
    else if (issue_direct) hmastlock_s = hmastlock_m;
  end
`else
  logic unused_lock;

  assign unused_lock = hmastlock_m;
  assign req         = req_base;
  assign hmastlock_s = 1'b0;
`endif

endmodule
